cc_branch_eval: RTL and testbench

Condition-code generation, storage and branch-resolution unit for the LC-3b out-of-order core's commit stage. It derives N/Z/P flags from a 16-bit committed result and latches them into a 3-bit CC register when the committing instruction writes CC. It evaluates a branch's nzp mask against the stored CC to produce the taken decision. An optional comparison against the fetch-time prediction flags a misprediction for flush.

---
 rtl/cc_branch_eval.sv | 65 ++++++
 tb/tb_cc_branch_eval.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cc_branch_eval.sv
// LC-3b commit-stage condition codes: N/Z/P generation, CC register and branch resolution.
// Optional MISPREDICT_EN adds br_valid/predict_in ports and the mispredict flag.
module cc_branch_eval #(
  parameter int unsigned data_width = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ld_cc,
  input  logic [data_width-1:0] value_in,
  input  logic [2:0]            dest_in,
  output logic [2:0]            gencc_out,
  output logic [2:0]            cc_out,
  output logic                  branch_enable
`ifdef MISPREDICT_EN
  ,
  input  logic                  br_valid,
  input  logic                  predict_in,
  output logic                  mispredict
`endif
);

  localparam logic [2:0] CcN = 3'b100;
  localparam logic [2:0] CcZ = 3'b010;
  localparam logic [2:0] CcP = 3'b001;

  logic [2:0] gencc;
  logic [2:0] cc_d;
  logic [2:0] cc_q;

  // Signed view of the result: sign bit first, then zero test; one-hot by construction.
  always_comb begin
    gencc = CcP;
    if (value_in[data_width-1]) begin
      gencc = CcN;
    end else if (value_in == '0) begin
      gencc = CcZ;
    end
  end

  always_comb begin
    cc_d = cc_q;
    if (ld_cc) begin
      cc_d = gencc;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cc_q <= CcZ;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign gencc_out = gencc;
  assign cc_out    = cc_q;

  // Branches resolve against the committed CC only, so a same-cycle load is not visible yet.
  assign branch_enable = |(cc_q & dest_in);

`ifdef MISPREDICT_EN
  assign mispredict = br_valid & (branch_enable != predict_in);
`endif

endmodule

// File: tb/tb_cc_branch_eval.sv
// Directed bench for cc_branch_eval; define MISPREDICT_EN to also cover the mispredict path.
module tb_cc_branch_eval;

  logic        clk;
  logic        clr;
  logic        ld_cc;
  logic [15:0] value_in;
  logic [2:0]  dest_in;
  logic [2:0]  gencc_out;
  logic [2:0]  cc_out;
  logic        branch_enable;
`ifdef MISPREDICT_EN
  logic        br_valid;
  logic        predict_in;
  logic        mispredict;
`endif

  int checks;
  int failures;

  cc_branch_eval #(
    .data_width(16)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .ld_cc        (ld_cc),
    .value_in     (value_in),
    .dest_in      (dest_in),
    .gencc_out    (gencc_out),
    .cc_out       (cc_out),
    .branch_enable(branch_enable)
`ifdef MISPREDICT_EN
    ,
    .br_valid     (br_valid),
    .predict_in   (predict_in),
    .mispredict   (mispredict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] hold_vals [5];
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    ld_cc    = 1'b0;
    value_in = 16'h0000;
    dest_in  = 3'b000;
`ifdef MISPREDICT_EN
    br_valid   = 1'b0;
    predict_in = 1'b0;
`endif
    tick();
    tick();
    clr = 1'b0;
    #1;

    // Reset state and branch compare against CC=Z
    chk("reset_cc", {13'd0, cc_out}, 16'h0002);
    dest_in = 3'b010; #1;
    chk("reset_br_z", {15'd0, branch_enable}, 16'h0001);
    dest_in = 3'b101; #1;
    chk("reset_br_np", {15'd0, branch_enable}, 16'h0000);
    dest_in = 3'b000; #1;
    chk("br_mask_none", {15'd0, branch_enable}, 16'h0000);
    dest_in = 3'b111; #1;
    chk("br_mask_all", {15'd0, branch_enable}, 16'h0001);

    // Load a negative value; branch sees old CC until the edge
    value_in = 16'h8000;
    ld_cc    = 1'b1;
    dest_in  = 3'b100;
    #1;
    chk("gencc_8000", {13'd0, gencc_out}, 16'h0004);
    chk("br_before_load", {15'd0, branch_enable}, 16'h0000);
    tick();
    ld_cc = 1'b0;
    #1;
    chk("cc_after_load_n", {13'd0, cc_out}, 16'h0004);
    chk("br_after_load_n", {15'd0, branch_enable}, 16'h0001);

    // Flag generation boundaries
    value_in = 16'h0000; #1;
    chk("gencc_0000", {13'd0, gencc_out}, 16'h0002);
    value_in = 16'h0001; #1;
    chk("gencc_0001", {13'd0, gencc_out}, 16'h0001);
    value_in = 16'h7FFF; #1;
    chk("gencc_7fff", {13'd0, gencc_out}, 16'h0001);
    value_in = 16'hFFFF; #1;
    chk("gencc_ffff", {13'd0, gencc_out}, 16'h0004);

    // Hold with ld_cc low
    hold_vals[0] = 16'h0000;
    hold_vals[1] = 16'h1234;
    hold_vals[2] = 16'h7FFF;
    hold_vals[3] = 16'h0001;
    hold_vals[4] = 16'hA5A5;
    for (int i = 0; i < 5; i++) begin
      value_in = hold_vals[i];
      tick();
      chk("cc_hold", {13'd0, cc_out}, 16'h0004);
    end

    // Consecutive loads each overwrite
    ld_cc    = 1'b1;
    value_in = 16'h0001;
    tick();
    chk("cc_consec_p", {13'd0, cc_out}, 16'h0001);
    value_in = 16'h0000;
    tick();
    chk("cc_consec_z", {13'd0, cc_out}, 16'h0002);
    value_in = 16'hFFFF;
    tick();
    chk("cc_consec_n", {13'd0, cc_out}, 16'h0004);

    // clr beats a simultaneous load
    clr      = 1'b1;
    value_in = 16'h0005;
    tick();
    clr   = 1'b0;
    ld_cc = 1'b0;
    chk("cc_clr_wins", {13'd0, cc_out}, 16'h0002);
    dest_in = 3'b001; #1;
    chk("br_after_clr_p", {15'd0, branch_enable}, 16'h0000);

    // Load P for branch/mispredict checks
    ld_cc    = 1'b1;
    value_in = 16'h0005;
    tick();
    ld_cc = 1'b0;
    #1;
    chk("cc_load_p", {13'd0, cc_out}, 16'h0001);
    chk("br_p_taken", {15'd0, branch_enable}, 16'h0001);

`ifdef MISPREDICT_EN
    br_valid   = 1'b1;
    predict_in = 1'b0; #1;
    chk("mis_pred_nt", {15'd0, mispredict}, 16'h0001);
    predict_in = 1'b1; #1;
    chk("mis_pred_t", {15'd0, mispredict}, 16'h0000);
    br_valid   = 1'b0;
    predict_in = 1'b0; #1;
    chk("mis_no_valid", {15'd0, mispredict}, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
